// File: rtl/led_status_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// led_status_pkg
//  Shared definitions for the front-panel LED driver.
//  - state_t : FSM state encoding (S_IDLE .. S_OVER)
//  - onehot  : one-hot LED pattern for a direction index, zero when the
//              index is out of range
// -----------------------------------------------------------------------------
package led_status_pkg;

   // Widest LED bank the onehot helper can describe; callers cast the
   // result down to their own NUM_LEDS width.
   localparam int unsigned MAX_LEDS = 32;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SHOW  = 3'd1,
      S_HOLD  = 3'd2,
      S_CHASE = 3'd3,
      S_BLINK = 3'd4,
      S_OVER  = 3'd5
   } state_t;

   function automatic logic [MAX_LEDS-1:0] onehot(input int unsigned idx,
                                                  input int unsigned n);
      logic [MAX_LEDS-1:0] v;
      v = '0;
      if (idx < n && idx < MAX_LEDS)
         v = {{(MAX_LEDS-1){1'b0}}, 1'b1} << idx;
      return v;
   endfunction

endpackage

// File: rtl/led_status_ctrl_cycle_timer.sv
// -----------------------------------------------------------------------------
// cycle_timer
//  Loadable down-counter that saturates at zero.
//  Ports:
//   clk, rst : clock, synchronous active-high reset (count -> 0)
//   load     : capture value (has priority over dec)
//   value    : reload value
//   dec      : decrement by one when the count is non-zero
//   done     : count is zero
// -----------------------------------------------------------------------------
module cycle_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] value,
   input  logic         dec,
   output logic         done
);

   logic [W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (rst)
         count_reg <= '0;
      else if (load)
         count_reg <= value;
      else if (dec && count_reg != '0)
         count_reg <= count_reg - W'(1);
   end

   assign done = (count_reg == '0);

endmodule

// File: rtl/led_status_ctrl.sv
// -----------------------------------------------------------------------------
// led_status_ctrl
//  Front-panel LED driver: one-hot direction display with release stretch,
//  level-up chase animation, and game-over blink followed by steady all-on.
//  Ports:
//   clk       : system clock
//   rst       : synchronous active-high reset
//   num       : direction index of the current press
//   pressed   : a direction button is held
//   game_over : game-over flag (level)
//   level_up  : one-cycle pulse when a level is cleared
//   leds      : registered LED drive
//   busy      : high while the chase or blink animation runs
// -----------------------------------------------------------------------------
module led_status_ctrl
   import led_status_pkg::*;
#(
   parameter int unsigned NUM_LEDS     = 4,
   parameter int unsigned HOLD_CYCLES  = 5_000_000,
   parameter int unsigned STEP_CYCLES  = 12_500_000,
   parameter int unsigned BLINK_CYCLES = 25_000_000,
   parameter int unsigned BLINK_COUNT  = 3,
   localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [IDX_W-1:0]    num,
   input  logic                pressed,
   input  logic                game_over,
   input  logic                level_up,
   output logic [NUM_LEDS-1:0] leds,
   output logic                busy
);

   localparam int unsigned MAX_HS  = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
   localparam int unsigned MAX_CYC = (MAX_HS > BLINK_CYCLES) ? MAX_HS : BLINK_CYCLES;
   localparam int TMR_W = $clog2(MAX_CYC) + 1;
   localparam int CNT_W = $clog2(2 * BLINK_COUNT + 1);

   localparam logic [TMR_W-1:0] HOLD_LOAD  = TMR_W'(HOLD_CYCLES - 1);
   localparam logic [TMR_W-1:0] STEP_LOAD  = TMR_W'(STEP_CYCLES - 1);
   localparam logic [TMR_W-1:0] BLINK_LOAD = TMR_W'(BLINK_CYCLES - 1);
   localparam logic [CNT_W-1:0] LAST_HALF  = CNT_W'(2 * BLINK_COUNT - 1);

   state_t              state_reg, state_next;
   logic [NUM_LEDS-1:0] leds_reg, leds_next;
   logic                busy_reg, busy_next;
   logic [CNT_W-1:0]    half_reg, half_next;

   logic                tmr_load, tmr_dec, tmr_done;
   logic [TMR_W-1:0]    tmr_value;

   logic                num_ok, press_ok;
   logic [NUM_LEDS-1:0] lit;

   // An out-of-range index is treated exactly like no press at all.
   assign num_ok   = (32'(num) < NUM_LEDS);
   assign press_ok = pressed && num_ok;
   assign lit      = NUM_LEDS'(onehot(32'(num), NUM_LEDS));

   // One timer is enough: hold, chase step and blink phases never overlap.
   cycle_timer #(.W(TMR_W)) u_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (tmr_load),
      .value (tmr_value),
      .dec   (tmr_dec),
      .done  (tmr_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_IDLE;
         leds_reg  <= '0;
         busy_reg  <= 1'b0;
         half_reg  <= '0;
      end else begin
         state_reg <= state_next;
         leds_reg  <= leds_next;
         busy_reg  <= busy_next;
         half_reg  <= half_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      leds_next  = leds_reg;
      half_next  = half_reg;
      tmr_load   = 1'b0;
      tmr_value  = '0;
      tmr_dec    = 1'b0;

      case (state_reg)
         S_IDLE, S_SHOW, S_HOLD, S_CHASE: begin
            if (game_over) begin
               state_next = S_BLINK;
               leds_next  = '1;
               half_next  = '0;
               tmr_load   = 1'b1;
               tmr_value  = BLINK_LOAD;
            end else if (state_reg == S_CHASE) begin
               // Chase ignores level_up and presses until the sweep ends.
               if (!tmr_done) begin
                  tmr_dec = 1'b1;
               end else if (leds_reg[NUM_LEDS-1]) begin
                  state_next = S_IDLE;
                  leds_next  = '0;
               end else begin
                  leds_next = leds_reg << 1;
                  tmr_load  = 1'b1;
                  tmr_value = STEP_LOAD;
               end
            end else if (level_up) begin
               state_next = S_CHASE;
               leds_next  = NUM_LEDS'(1);
               tmr_load   = 1'b1;
               tmr_value  = STEP_LOAD;
            end else if (press_ok) begin
               state_next = S_SHOW;
               leds_next  = lit;
            end else if (state_reg == S_SHOW) begin
               // Held with an out-of-range index keeps the last pattern.
               if (!pressed) begin
                  state_next = S_HOLD;
                  tmr_load   = 1'b1;
                  tmr_value  = HOLD_LOAD;
               end
            end else if (state_reg == S_HOLD) begin
               if (tmr_done) begin
                  state_next = S_IDLE;
                  leds_next  = '0;
               end else begin
                  tmr_dec = 1'b1;
               end
            end else begin
               leds_next = '0;
            end
         end

         S_BLINK: begin
            if (!game_over) begin
               state_next = S_IDLE;
               leds_next  = '0;
               half_next  = '0;
            end else if (!tmr_done) begin
               tmr_dec = 1'b1;
            end else if (half_reg == LAST_HALF) begin
               // Last half-period was dark; inverting lands on all-on.
               state_next = S_OVER;
               leds_next  = ~leds_reg;
               half_next  = '0;
            end else begin
               leds_next = ~leds_reg;
               half_next = half_reg + CNT_W'(1);
               tmr_load  = 1'b1;
               tmr_value = BLINK_LOAD;
            end
         end

         S_OVER: begin
            if (!game_over) begin
               state_next = S_IDLE;
               leds_next  = '0;
            end else begin
               leds_next = '1;
            end
         end

         default: begin
            state_next = S_IDLE;
            leds_next  = '0;
            half_next  = '0;
         end
      endcase

      busy_next = (state_next == S_CHASE) || (state_next == S_BLINK);
   end

   assign leds = leds_reg;
   assign busy = busy_reg;

endmodule

// File: tb/tb_led_status_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_status_ctrl
//  Scenario-driven bench for led_status_ctrl with short timing parameters.
//  Each scenario lists per-cycle inputs with the LED/busy values expected on
//  the following cycle; expectations travel through a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_led_status_ctrl;

   typedef struct packed {
      logic       rst;
      logic       pressed;
      logic [1:0] num;
      logic       game_over;
      logic       level_up;
      logic [3:0] exp_leds;
      logic       exp_busy;
   } stim_t;

   typedef struct packed {
      logic [3:0] leds;
      logic       busy;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] num;
   logic       pressed;
   logic       game_over;
   logic       level_up;
   logic [3:0] leds;
   logic       busy;

   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   led_status_ctrl #(
      .NUM_LEDS     (4),
      .HOLD_CYCLES  (3),
      .STEP_CYCLES  (2),
      .BLINK_CYCLES (2),
      .BLINK_COUNT  (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .num       (num),
      .pressed   (pressed),
      .game_over (game_over),
      .level_up  (level_up),
      .leds      (leds),
      .busy      (busy)
   );

   function automatic stim_t mk(input logic r, input logic p, input logic [1:0] n,
                                input logic go, input logic lu,
                                input logic [3:0] el, input logic eb);
      stim_t s;
      s.rst = r; s.pressed = p; s.num = n; s.game_over = go; s.level_up = lu;
      s.exp_leds = el; s.exp_busy = eb;
      return s;
   endfunction

   task automatic test_reset();
      stim_t v[$];
      exp_t  e;
      v.push_back(mk(1, 0, 0, 0, 0, 4'b0000, 0));
      v.push_back(mk(1, 0, 0, 0, 0, 4'b0000, 0));
      v.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 0));
      foreach (v[i]) begin
         rst = v[i].rst; pressed = v[i].pressed; num = v[i].num;
         game_over = v[i].game_over; level_up = v[i].level_up;
         sb.push_back('{leds: v[i].exp_leds, busy: v[i].exp_busy});
         @(posedge clk); #1; cyc++;
         e = sb.pop_front();
         n_vec++;
         if (leds !== e.leds || busy !== e.busy) begin
            n_err++;
            $display("FAIL reset step %0d: leds=%b busy=%b, want leds=%b busy=%b", i, leds, busy, e.leds, e.busy);
         end else
            $display("ok   reset step %0d cyc %0d: leds=%b busy=%b", i, cyc, leds, busy);
      end
   endtask

   task automatic test_reset_mid_chase();
      stim_t v[$];
      exp_t  e;
      v.push_back(mk(0, 0, 0, 0, 1, 4'b0001, 1));
      v.push_back(mk(0, 0, 0, 0, 0, 4'b0001, 1));
      v.push_back(mk(0, 0, 0, 0, 0, 4'b0010, 1));
      v.push_back(mk(1, 0, 0, 0, 0, 4'b0000, 0));
      v.push_back(mk(1, 0, 0, 0, 0, 4'b0000, 0));
      v.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 0));
      v.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 0));
      v.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 0));
      foreach (v[i]) begin
         rst = v[i].rst; pressed = v[i].pressed; num = v[i].num;
         game_over = v[i].game_over; level_up = v[i].level_up;
         sb.push_back('{leds: v[i].exp_leds, busy: v[i].exp_busy});
         @(posedge clk); #1; cyc++;
         e = sb.pop_front();
         n_vec++;
         if (leds !== e.leds || busy !== e.busy) begin
            n_err++;
            $display("FAIL reset_mid_chase step %0d: leds=%b busy=%b, want leds=%b busy=%b", i, leds, busy, e.leds, e.busy);
         end else
            $display("ok   reset_mid_chase step %0d cyc %0d: leds=%b busy=%b", i, cyc, leds, busy);
      end
   endtask

   task automatic test_press_hold();
      stim_t v[$];
      exp_t  e;
      v.push_back(mk(0, 1, 2, 0, 0, 4'b0100, 0));
      v.push_back(mk(0, 1, 2, 0, 0, 4'b0100, 0));
      v.push_back(mk(0, 1, 3, 0, 0, 4'b1000, 0));
      v.push_back(mk(0, 1, 3, 0, 0, 4'b1000, 0));
      v.push_back(mk(0, 0, 0, 0, 0, 4'b1000, 0));   // release
      v.push_back(mk(0, 0, 0, 0, 0, 4'b1000, 0));
      v.push_back(mk(0, 0, 0, 0, 0, 4'b1000, 0));
      v.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 0));   // exactly 3 lit cycles
      v.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 0));
      foreach (v[i]) begin
         rst = v[i].rst; pressed = v[i].pressed; num = v[i].num;
         game_over = v[i].game_over; level_up = v[i].level_up;
         sb.push_back('{leds: v[i].exp_leds, busy: v[i].exp_busy});
         @(posedge clk); #1; cyc++;
         e = sb.pop_front();
         n_vec++;
         if (leds !== e.leds || busy !== e.busy) begin
            n_err++;
            $display("FAIL press_hold step %0d: leds=%b busy=%b, want leds=%b busy=%b", i, leds, busy, e.leds, e.busy);
         end else
            $display("ok   press_hold step %0d cyc %0d: leds=%b busy=%b", i, cyc, leds, busy);
      end
   endtask

   task automatic test_repress_in_hold();
      stim_t v[$];
      exp_t  e;
      v.push_back(mk(0, 1, 1, 0, 0, 4'b0010, 0));
      v.push_back(mk(0, 0, 0, 0, 0, 4'b0010, 0));
      v.push_back(mk(0, 0, 0, 0, 0, 4'b0010, 0));
      v.push_back(mk(0, 1, 0, 0, 0, 4'b0001, 0));   // re-press, no gap
      v.push_back(mk(0, 1, 0, 0, 0, 4'b0001, 0));
      v.push_back(mk(0, 0, 0, 0, 0, 4'b0001, 0));
      v.push_back(mk(0, 0, 0, 0, 0, 4'b0001, 0));
      v.push_back(mk(0, 0, 0, 0, 0, 4'b0001, 0));
      v.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 0));
      foreach (v[i]) begin
         rst = v[i].rst; pressed = v[i].pressed; num = v[i].num;
         game_over = v[i].game_over; level_up = v[i].level_up;
         sb.push_back('{leds: v[i].exp_leds, busy: v[i].exp_busy});
         @(posedge clk); #1; cyc++;
         e = sb.pop_front();
         n_vec++;
         if (leds !== e.leds || busy !== e.busy) begin
            n_err++;
            $display("FAIL repress step %0d: leds=%b busy=%b, want leds=%b busy=%b", i, leds, busy, e.leds, e.busy);
         end else
            $display("ok   repress step %0d cyc %0d: leds=%b busy=%b", i, cyc, leds, busy);
      end
   endtask

   task automatic test_chase();
      stim_t v[$];
      exp_t  e;
      v.push_back(mk(0, 0, 0, 0, 1, 4'b0001, 1));
      v.push_back(mk(0, 0, 0, 0, 0, 4'b0001, 1));
      v.push_back(mk(0, 0, 0, 0, 0, 4'b0010, 1));
      v.push_back(mk(0, 1, 2, 0, 1, 4'b0010, 1));   // restart attempt + press ignored
      v.push_back(mk(0, 0, 0, 0, 0, 4'b0100, 1));
      v.push_back(mk(0, 0, 0, 0, 0, 4'b0100, 1));
      v.push_back(mk(0, 0, 0, 0, 0, 4'b1000, 1));
      v.push_back(mk(0, 0, 0, 0, 0, 4'b1000, 1));
      v.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 0));
      v.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 0));
      foreach (v[i]) begin
         rst = v[i].rst; pressed = v[i].pressed; num = v[i].num;
         game_over = v[i].game_over; level_up = v[i].level_up;
         sb.push_back('{leds: v[i].exp_leds, busy: v[i].exp_busy});
         @(posedge clk); #1; cyc++;
         e = sb.pop_front();
         n_vec++;
         if (leds !== e.leds || busy !== e.busy) begin
            n_err++;
            $display("FAIL chase step %0d: leds=%b busy=%b, want leds=%b busy=%b", i, leds, busy, e.leds, e.busy);
         end else
            $display("ok   chase step %0d cyc %0d: leds=%b busy=%b", i, cyc, leds, busy);
      end
   endtask

   // Game over preempts a chase, then release into a press (leaves SHOW).
   task automatic test_game_over();
      stim_t v[$];
      exp_t  e;
      v.push_back(mk(0, 0, 0, 0, 1, 4'b0001, 1));
      v.push_back(mk(0, 0, 0, 0, 0, 4'b0001, 1));
      v.push_back(mk(0, 0, 0, 1, 0, 4'b1111, 1));
      v.push_back(mk(0, 0, 0, 1, 0, 4'b1111, 1));
      v.push_back(mk(0, 0, 0, 1, 0, 4'b0000, 1));
      v.push_back(mk(0, 0, 0, 1, 0, 4'b0000, 1));
      v.push_back(mk(0, 0, 0, 1, 0, 4'b1111, 1));
      v.push_back(mk(0, 0, 0, 1, 0, 4'b1111, 1));
      v.push_back(mk(0, 0, 0, 1, 0, 4'b0000, 1));
      v.push_back(mk(0, 0, 0, 1, 0, 4'b0000, 1));
      v.push_back(mk(0, 0, 0, 1, 0, 4'b1111, 0));   // OVER
      v.push_back(mk(0, 1, 1, 1, 1, 4'b1111, 0));
      v.push_back(mk(0, 0, 0, 1, 0, 4'b1111, 0));
      v.push_back(mk(0, 1, 1, 0, 0, 4'b0000, 0));   // pressed ignored on exit
      v.push_back(mk(0, 1, 1, 0, 0, 4'b0010, 0));
      foreach (v[i]) begin
         rst = v[i].rst; pressed = v[i].pressed; num = v[i].num;
         game_over = v[i].game_over; level_up = v[i].level_up;
         sb.push_back('{leds: v[i].exp_leds, busy: v[i].exp_busy});
         @(posedge clk); #1; cyc++;
         e = sb.pop_front();
         n_vec++;
         if (leds !== e.leds || busy !== e.busy) begin
            n_err++;
            $display("FAIL game_over step %0d: leds=%b busy=%b, want leds=%b busy=%b", i, leds, busy, e.leds, e.busy);
         end else
            $display("ok   game_over step %0d cyc %0d: leds=%b busy=%b", i, cyc, leds, busy);
      end
   endtask

   // Simultaneous requests: game_over beats level_up beats pressed.
   task automatic test_back_to_back();
      stim_t v[$];
      exp_t  e;
      v.push_back(mk(1, 0, 0, 0, 0, 4'b0000, 0));
      v.push_back(mk(0, 1, 3, 1, 1, 4'b1111, 1));
      v.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 0));
      v.push_back(mk(0, 1, 3, 0, 1, 4'b0001, 1));
      v.push_back(mk(0, 1, 3, 0, 0, 4'b0001, 1));
      v.push_back(mk(0, 1, 3, 1, 0, 4'b1111, 1));
      v.push_back(mk(0, 1, 2, 0, 0, 4'b0000, 0));
      v.push_back(mk(0, 1, 2, 0, 0, 4'b0100, 0));
      foreach (v[i]) begin
         rst = v[i].rst; pressed = v[i].pressed; num = v[i].num;
         game_over = v[i].game_over; level_up = v[i].level_up;
         sb.push_back('{leds: v[i].exp_leds, busy: v[i].exp_busy});
         @(posedge clk); #1; cyc++;
         e = sb.pop_front();
         n_vec++;
         if (leds !== e.leds || busy !== e.busy) begin
            n_err++;
            $display("FAIL back_to_back step %0d: leds=%b busy=%b, want leds=%b busy=%b", i, leds, busy, e.leds, e.busy);
         end else
            $display("ok   back_to_back step %0d cyc %0d: leds=%b busy=%b", i, cyc, leds, busy);
      end
   endtask

   initial begin
      rst = 1'b1; pressed = 1'b0; num = 2'd0; game_over = 1'b0; level_up = 1'b0;
      test_reset();
      test_reset_mid_chase();
      test_press_hold();
      test_repress_in_hold();
      test_chase();
      test_game_over();
      test_back_to_back();
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
